unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Shares the single unified memory port between the instruction-fetch requester and the LSU data requester. It sits between fetch/LSU and the memory model. It serialises accesses with a one-outstanding-transaction FSM, prioritises data over fetch with a starvation guard, and routes each response back to the requester that owns it. Fetch and LSU read a `gnt`/`rvalid` handshake and stall on it.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while fetch waits; range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `if_req_i` in 1 / `if_addr_i` in 64: fetch request and byte address.
- `if_gnt_o`  out  1  fetch request accepted this cycle.
- `if_rvalid_o` out 1 / `if_rdata_o` out 32: fetch response and 32-bit instruction word.
- `d_req_i`, `d_we_i` in 1; `d_be_i` in 8; `d_addr_i`, `d_wdata_i` in 64: LSU request.
- `d_gnt_o`  out  1  LSU request accepted.
- `d_rvalid_o` out 1 / `d_rdata_o` out 64: LSU response; also sent for writes as an acknowledgement.
- `mem_req_o`, `mem_we_o` out 1; `mem_be_o` out 8; `mem_addr_o`, `mem_wdata_o` out 64: memory request.
- `mem_gnt_i` in 1 / `mem_rvalid_i` in 1 / `mem_rdata_i` in 64: memory accept and response.
- `perf_if_gnt_o`, `perf_d_gnt_o`, `perf_conflict_o`  out  32  performance counters (see Configuration).

## Operation
- FSM has two states.
  - IDLE: requests may be issued.
  - BUSY: one transaction is outstanding; `owner` register holds IF or D.
- Arbitration happens in IDLE only.
  - Default winner: D beats IF.
  - Exception: IF wins when `if_req_i` is high and `streak == STARVE_LIMIT`.
- Memory request outputs come combinationally from the winner.
  - Fetch winner: `mem_we_o=0`, `mem_be_o=8'hFF`.
  - No requester (or in BUSY): `mem_req_o=0`, and all other `mem_*` outputs are 0.
- Grant: `x_gnt_o = mem_req_o & mem_gnt_i & (winner==x)`.
  - On a grant, the FSM moves IDLE→BUSY and latches `owner` and `if_addr_i[2]`.
- Requesters hold the request and its payload stable until they are granted. A loser is not acknowledged and keeps waiting.
- In BUSY, `mem_rvalid_i` is routed to `owner`'s `rvalid` output and the FSM moves BUSY→IDLE.
  - No new request is issued in the rvalid cycle itself.
- `if_rdata_o` is `mem_rdata_i[63:32]` when the latched `addr[2]` is 1, otherwise `mem_rdata_i[31:0]`.
- `d_rdata_o` is `mem_rdata_i` unchanged.
- `mem_rvalid_i` in IDLE is ignored; no output asserts.
- Streak counter, 4-bit:
  - Increments on a D grant while `if_req_i` is high.
  - Clears on an IF grant, or on any cycle with `if_req_i` low.
  - Saturates at `STARVE_LIMIT`.
- Both rvalid outputs are 0 when their requester is not `owner`. The rdata outputs are don't-care whenever the matching rvalid is low.

## Timing
- Reset values:
  - State IDLE, `owner=IF`, `streak=0`, all counters 0.
  - All `gnt`/`rvalid`/`mem_req` outputs are 0.
- Reset mid-transaction returns the FSM to IDLE and drops the pending response. A late `mem_rvalid_i` after reset is ignored.
- Request-to-grant latency is 0 cycles with the combinational path `if_req_i`/`d_req_i` → `mem_req_o`. Grant requires `mem_gnt_i` in the same cycle.
- Response latency equals the memory latency, minimum 1 cycle after grant.
- Peak throughput is one transaction per 2 cycles: grant, then rvalid.
- Simultaneous requests: D wins unless the starvation condition holds, so IF waits at most `STARVE_LIMIT` D transactions.

## Configuration
- `MEM_ARB_PERF_EN` defined:
  - `perf_if_gnt_o` and `perf_d_gnt_o` increment on each respective grant.
  - `perf_conflict_o` increments on every IDLE cycle with both requests high.
  - All three are 32-bit, wrap on overflow, and clear on reset.
- Not defined: the counter logic is absent and all three ports are tied to 0.

## Structure
- `riscv_pkg` holds:
  - `arb_owner_t` enum: `OWN_IF`, `OWN_D`.
  - `arb_state_t` enum: `ARB_IDLE`, `ARB_BUSY`.
  - `ARB_STREAK_W = 4`.
- Sub-module `mem_arb_perf` holds the three counters. It is instantiated only under `MEM_ARB_PERF_EN`.

## Test plan
- Fetch only: `if_req` with addr `0x1004`, `mem_gnt=1`, `mem_rdata=0xAAAA_BBBB_CCCC_DDDD` one cycle later → `if_gnt` in cycle 0, `if_rvalid` with rdata `0xAAAABBBB` in cycle 1.
- Simultaneous IF+D read of `0x2000` → `d_gnt` first; `if_gnt` follows 2 cycles after the D grant when memory latency is 1.
- Starvation: D requests back-to-back, IF held high, `STARVE_LIMIT=4` → exactly 4 D grants, then an IF grant, then D resumes.
- Backpressure: `mem_gnt=0` for 3 cycles with `d_req`, `we=1`, `be=0x0F` → no `d_gnt`, outputs stable; grant on cycle 3; write ack via `d_rvalid`.
- Reset during BUSY, then `mem_rvalid` pulse → no rvalid output; the next `if_req` is granted normally.
- `MEM_ARB_PERF_EN`: 3 conflict cycles, 2 IF and 5 D grants → counters read 3/2/5. Without the macro → counters read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and widths for the unified memory arbiter.
package riscv_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned ARB_STREAK_W = 4;
  localparam int unsigned ARB_PERF_W   = 32;

  // Picks the 32-bit instruction word out of a 64-bit memory beat.
  function automatic logic [31:0] arb_fetch_word(input logic [63:0] beat, input logic hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Grant and conflict event counters for the arbiter; only built under MEM_ARB_PERF_EN.
module mem_arb_perf
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_gnt_i,
  input  logic                  d_gnt_i,
  input  logic                  conflict_i,
  output logic [ARB_PERF_W-1:0] perf_if_gnt_o,
  output logic [ARB_PERF_W-1:0] perf_d_gnt_o,
  output logic [ARB_PERF_W-1:0] perf_conflict_o
);

  logic [ARB_PERF_W-1:0] if_cnt_q, if_cnt_d;
  logic [ARB_PERF_W-1:0] d_cnt_q, d_cnt_d;
  logic [ARB_PERF_W-1:0] conf_cnt_q, conf_cnt_d;

  // Counters wrap naturally on overflow.
  always_comb begin
    if_cnt_d   = if_cnt_q + ARB_PERF_W'(if_gnt_i);
    d_cnt_d    = d_cnt_q + ARB_PERF_W'(d_gnt_i);
    conf_cnt_d = conf_cnt_q + ARB_PERF_W'(conflict_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_cnt_q   <= '0;
      d_cnt_q    <= '0;
      conf_cnt_q <= '0;
    end else begin
      if_cnt_q   <= if_cnt_d;
      d_cnt_q    <= d_cnt_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign perf_if_gnt_o   = if_cnt_q;
  assign perf_d_gnt_o    = d_cnt_q;
  assign perf_conflict_o = conf_cnt_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and LSU.
// Performance counters are built only when MEM_ARB_PERF_EN is defined.
//
//   state    | meaning
//   ARB_IDLE | arbitrate; winner drives the memory request
//   ARB_BUSY | one transaction outstanding, owner_q gets the response
module unified_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [7:0]  d_be_i,
  input  logic [63:0] d_addr_i,
  input  logic [63:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [63:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_be_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  output logic [31:0] perf_if_gnt_o,
  output logic [31:0] perf_d_gnt_o,
  output logic [31:0] perf_conflict_o
);

  localparam logic [ARB_STREAK_W-1:0] LIMIT = ARB_STREAK_W'(STARVE_LIMIT);

  arb_state_t                state_q, state_d;
  arb_owner_t                owner_q, owner_d;
  logic                      addr2_q, addr2_d;
  logic [ARB_STREAK_W-1:0]   streak_q, streak_d;

  logic idle;
  logic if_win;
  logic d_win;
  logic resp;

  always_comb begin
    idle   = (state_q == ARB_IDLE);
    if_win = idle && if_req_i && (!d_req_i || (streak_q == LIMIT));
    d_win  = idle && d_req_i && !if_win;

    mem_req_o   = if_win || d_win;
    mem_we_o    = 1'b0;
    mem_be_o    = 8'h00;
    mem_addr_o  = 64'h0;
    mem_wdata_o = 64'h0;
    if (if_win) begin
      mem_be_o   = 8'hFF;
      mem_addr_o = if_addr_i;
    end else if (d_win) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end

    if_gnt_o = if_win && mem_gnt_i;
    d_gnt_o  = d_win && mem_gnt_i;

    // A response is only meaningful while a transaction is outstanding.
    resp        = !idle && mem_rvalid_i;
    if_rvalid_o = resp && (owner_q == OWN_IF);
    d_rvalid_o  = resp && (owner_q == OWN_D);
    if_rdata_o  = arb_fetch_word(mem_rdata_i, addr2_q);
    d_rdata_o   = mem_rdata_i;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr2_d  = addr2_q;
    streak_d = streak_q;

    if (if_gnt_o) begin
      state_d = ARB_BUSY;
      owner_d = OWN_IF;
      addr2_d = if_addr_i[2];
    end else if (d_gnt_o) begin
      state_d = ARB_BUSY;
      owner_d = OWN_D;
    end else if (resp) begin
      state_d = ARB_IDLE;
    end

    // Streak counts D grants that overtook a waiting fetch.
    if (!if_req_i || if_gnt_o) begin
      streak_d = '0;
    end else if (d_gnt_o && (streak_q != LIMIT)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IF;
      addr2_q  <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr2_q  <= addr2_d;
      streak_q <= streak_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic conflict;
  assign conflict = idle && if_req_i && d_req_i;

  mem_arb_perf u_perf (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_gnt_i        (if_gnt_o),
    .d_gnt_i         (d_gnt_o),
    .conflict_i      (conflict),
    .perf_if_gnt_o   (perf_if_gnt_o),
    .perf_d_gnt_o    (perf_d_gnt_o),
    .perf_conflict_o (perf_conflict_o)
  );
`else
  assign perf_if_gnt_o   = 32'h0;
  assign perf_d_gnt_o    = 32'h0;
  assign perf_conflict_o = 32'h0;
`endif

endmodule
